// File: rtl/phy_tx_pkg.sv
//------------------------------------------------------------------------------
// Module   : phy_tx_pkg
// Purpose  : Shared constants, lane-index width helper and drain FSM states
//            for the PHY transmit lane serializer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package phy_tx_pkg;

    // K28.5 comma symbol, driven on the serial stream while idle.
    localparam logic [7:0] COM_SYM = 8'hBC;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } drain_state_e;

    function automatic int lane_idx_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage : phy_tx_pkg

`default_nettype wire

// File: rtl/phy_tx_group_fifo.sv
//------------------------------------------------------------------------------
// Module   : phy_tx_group_fifo
// Purpose  : DEPTH-entry group buffer with a combinational head view and an
//            occupancy count; pushes while full and pops while empty are ignored.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module phy_tx_group_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW  = $clog2(DEPTH);
    localparam int LVW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LVW-1:0]   r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == LVW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_level = r_level;

    // Storage carries no reset; validity is tracked purely by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVW'(1);
                2'b01:   r_level <= r_level - LVW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule : phy_tx_group_fifo

`default_nettype wire

// File: rtl/phy_tx_lane_serializer.sv
//------------------------------------------------------------------------------
// Module   : phy_tx_lane_serializer
// Purpose  : Buffers parallel lane groups and drains their valid lanes, lowest
//            lane first, onto a registered one-word-per-cycle serial stream.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module phy_tx_lane_serializer
    import phy_tx_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                LANES    = 4,
    parameter int                DEPTH    = 4,
    parameter logic [DATA_W-1:0] IDLE_SYM = DATA_W'(COM_SYM)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [LANES*DATA_W-1:0]     in_data,
    input  logic [LANES-1:0]            in_valid,
    output logic                        in_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_valid,
    output logic [$clog2(LANES)-1:0]    out_lane,
    output logic                        out_last,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        overflow
);

    localparam int LW  = lane_idx_w(LANES);
    localparam int GW  = LANES * DATA_W;
    localparam int EW  = GW + LANES;
    localparam int LVW = $clog2(DEPTH) + 1;

    logic [EW-1:0]     w_head;
    logic [GW-1:0]     w_head_data;
    logic [LANES-1:0]  w_head_mask;
    logic [LVW-1:0]    w_level;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    drain_state_e      r_state;
    drain_state_e      w_state_nxt;
    logic [LANES-1:0]  r_rem_mask;
    logic [LANES-1:0]  w_rem_nxt;
    logic [LANES-1:0]  w_cur_mask;
    logic [LANES-1:0]  w_sel_onehot;
    logic [LW-1:0]     w_sel_idx;
    logic [DATA_W-1:0] w_word;
    logic              w_issue;
    logic              w_last;
    logic              w_more;

    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic [LW-1:0]     r_out_lane;
    logic              r_out_last;
    logic              r_overflow;

    assign w_push = (|in_valid) & ~w_full;

    phy_tx_group_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_group_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata ({in_valid, in_data}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head_data = w_head[GW-1:0];
    assign w_head_mask = w_head[EW-1:GW];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // An empty remaining mask while sending means the next head is loaded now.
    always_comb begin
        w_state_nxt  = r_state;
        w_cur_mask   = w_head_mask;
        w_sel_idx    = '0;
        w_sel_onehot = '0;
        w_rem_nxt    = '0;
        w_issue      = 1'b0;
        w_last       = 1'b0;
        w_pop        = 1'b0;
        w_more       = (w_level > LVW'(1)) || w_push;

        if ((r_state == ST_SEND) && (r_rem_mask != '0)) begin
            w_cur_mask = r_rem_mask;
        end

        for (int i = LANES - 1; i >= 0; i--) begin
            if (w_cur_mask[i]) begin
                w_sel_idx       = LW'(i);
                w_sel_onehot    = '0;
                w_sel_onehot[i] = 1'b1;
            end
        end

        case (r_state)
            ST_IDLE: begin
                w_issue = ~w_empty;
            end
            ST_SEND: begin
                w_issue = 1'b1;
            end
            default: begin
                w_issue = 1'b0;
            end
        endcase

        if (w_issue) begin
            w_rem_nxt   = w_cur_mask & ~w_sel_onehot;
            w_last      = (w_rem_nxt == '0);
            w_pop       = w_last;
            w_state_nxt = (!w_last || w_more) ? ST_SEND : ST_IDLE;
        end else begin
            w_state_nxt = ST_IDLE;
        end
    end

    assign w_word = w_head_data[w_sel_idx*DATA_W +: DATA_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rem_mask  <= '0;
            r_out_data  <= IDLE_SYM;
            r_out_valid <= 1'b0;
            r_out_lane  <= '0;
            r_out_last  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_rem_mask <= w_issue ? w_rem_nxt : '0;
            if (w_issue) begin
                r_out_data  <= w_word;
                r_out_valid <= 1'b1;
                r_out_lane  <= w_sel_idx;
                r_out_last  <= w_last;
            end else begin
                r_out_data  <= IDLE_SYM;
                r_out_valid <= 1'b0;
                r_out_lane  <= '0;
                r_out_last  <= 1'b0;
            end
            if ((|in_valid) && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign in_ready  = ~w_full;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_lane  = r_out_lane;
    assign out_last  = r_out_last;
    assign level     = w_level;
    assign overflow  = r_overflow;

endmodule : phy_tx_lane_serializer

`default_nettype wire

// File: tb/tb_phy_tx_lane_serializer.sv
//------------------------------------------------------------------------------
// Module   : tb_phy_tx_lane_serializer
// Purpose  : Directed, table-driven self-checking bench for the lane serializer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_phy_tx_lane_serializer;

    localparam logic [7:0] C_IDLE = 8'hBC;

    logic        clk;
    logic        reset;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic [1:0]  out_lane;
    logic        out_last;
    logic [2:0]  level;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0]     data;
        logic [3:0]      valid;
        int              n;
        logic [3:0][7:0] ed;
        logic [3:0][1:0] el;
    } vec_t;

    vec_t vecs [5];

    phy_tx_lane_serializer dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_lane  (out_lane),
        .out_last  (out_last),
        .level     (level),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_pack();
        return {20'h0, out_valid, out_last, out_lane, out_data};
    endfunction

    initial begin
        vecs[0] = '{32'hCCDDEEFF, 4'b1111, 4, {8'hCC, 8'hDD, 8'hEE, 8'hFF}, {2'd3, 2'd2, 2'd1, 2'd0}};
        vecs[1] = '{32'h55775555, 4'b0100, 1, {24'h0, 8'h77}, {6'd0, 2'd2}};
        vecs[2] = '{32'h44332211, 4'b1010, 2, {16'h0, 8'h44, 8'h22}, {4'd0, 2'd3, 2'd1}};
        vecs[3] = '{32'h44332211, 4'b1001, 2, {16'h0, 8'h44, 8'h11}, {4'd0, 2'd3, 2'd0}};
        vecs[4] = '{32'h12345678, 4'b0000, 0, 32'h0, 8'h0};

        reset    = 1'b0;
        in_data  = '0;
        in_valid = '0;
        #3 reset = 1'b1;
        #1;
        check("reset_word", word_pack(), {20'h0, 1'b0, 1'b0, 2'd0, C_IDLE});
        check("reset_level", 32'(level), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Single-group vectors
        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            in_data  = vecs[v].data;
            in_valid = vecs[v].valid;
            @(negedge clk);
            in_valid = '0;
            check("vec_latency", 32'(out_valid), 32'd0);
            check("vec_level", 32'(level), (vecs[v].n > 0) ? 32'd1 : 32'd0);
            for (int w = 0; w < vecs[v].n; w++) begin
                @(negedge clk);
                check("vec_word", word_pack(),
                      {20'h0, 1'b1, (w == vecs[v].n - 1), vecs[v].el[w], vecs[v].ed[w]});
            end
            @(negedge clk);
            check("vec_idle", word_pack(), {20'h0, 1'b0, 1'b0, 2'd0, C_IDLE});
            check("vec_level_end", 32'(level), 32'd0);
        end

        // Back-to-back groups must stream without a bubble
        begin
            logic [7:0] exp_b2b [8];
            exp_b2b = '{8'hFF, 8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h99, 8'h88};
            @(negedge clk);
            in_data  = 32'hCCDDEEFF;
            in_valid = 4'b1111;
            @(negedge clk);
            in_data  = 32'h8899AABB;
            @(negedge clk);
            in_valid = '0;
            for (int w = 0; w < 8; w++) begin
                check("b2b_word", word_pack(),
                      {20'h0, 1'b1, (w % 4 == 3), 2'(w % 4), exp_b2b[w]});
                @(negedge clk);
            end
            check("b2b_idle", word_pack(), {20'h0, 1'b0, 1'b0, 2'd0, C_IDLE});
        end

        // Six groups on consecutive cycles; group 4 hits a full buffer and is lost
        repeat (2) @(negedge clk);
        for (int j = 0; j < 25; j++) begin
            if (j < 6) begin
                for (int l = 0; l < 4; l++) in_data[l*8 +: 8] = {4'(j), 4'(l)};
                in_valid = 4'b1111;
            end else begin
                in_valid = '0;
            end
            @(negedge clk);
            if (j == 2) check("ovf_not_yet", 32'(overflow), 32'd0);
            if (j == 3) check("full_level", {28'h0, in_ready, level}, {28'h0, 1'b0, 3'd4});
            if (j == 4) check("ovf_set", 32'(overflow), 32'd1);
            if ((j >= 1) && (j <= 20)) begin
                int w, gi;
                w  = j - 1;
                gi = (w / 4 < 4) ? (w / 4) : 5;
                check("full_word", word_pack(),
                      {20'h0, 1'b1, (w % 4 == 3), 2'(w % 4), 4'(gi), 4'(w % 4)});
            end else begin
                check("full_idle", word_pack(), {20'h0, 1'b0, 1'b0, 2'd0, C_IDLE});
            end
        end
        check("full_drained", {28'h0, overflow, level}, {28'h0, 1'b1, 3'd0});

        // Reset in the middle of a group
        @(negedge clk);
        in_data  = 32'hCCDDEEFF;
        in_valid = 4'b1111;
        @(negedge clk);
        in_valid = '0;
        repeat (2) @(negedge clk);
        check("mid_second_word", word_pack(), {20'h0, 1'b1, 1'b0, 2'd1, 8'hEE});
        #2 reset = 1'b1;
        #1;
        check("mid_rst_word", word_pack(), {20'h0, 1'b0, 1'b0, 2'd0, C_IDLE});
        check("mid_rst_state", {28'h0, overflow, level}, {28'h0, 1'b0, 3'd0});
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("post_rst_idle", word_pack(), {20'h0, 1'b0, 1'b0, 2'd0, C_IDLE});
        end
        check("post_rst_level", {28'h0, in_ready, level}, {28'h0, 1'b1, 3'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_phy_tx_lane_serializer

`default_nettype wire
